// File: rtl/fifo_prog_pkg.sv
// fifo_prog_pkg: default parameters, width helper and pointer-wrap helper
// shared by the programmable FIFO and its storage array.
package fifo_prog_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int AE_THRESH_DEF  = 1;

    // Encodes {write accepted, read accepted} for the occupancy update.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wrap by explicit compare so non-power-of-two depths index correctly.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_prog_mem.sv
// fifo_prog_mem: simple dual-port storage, one synchronous write port and
// one asynchronous read port.
module fifo_prog_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; contents are only meaningful once written,
    // and leaving it unreset lets it map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_prog.sv
// fifo_prog: parametrised single-clock FIFO with programmable thresholds,
// occupancy count and flush. Define FIFO_FWFT_EN for first-word-fall-through.
module fifo_prog
    import fifo_prog_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = AE_THRESH_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              wr_en,
    input  logic [FIFO_WIDTH-1:0]             data_in,
    input  logic                              rd_en,
    output logic [FIFO_WIDTH-1:0]             data_out,
    output logic                              wr_ack,
    output logic                              overflow,
    output logic                              underflow,
    output logic                              full,
    output logic                              empty,
    output logic                              almostfull,
    output logic                              almostempty,
    output logic [cnt_width(FIFO_DEPTH)-1:0]  count
);

    localparam int CW = cnt_width(FIFO_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;
    logic [FIFO_WIDTH-1:0] rdata;
    fifo_op_e              op;

    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= AF_C) && !full;
    assign almostempty = (count_q <= AE_C) && !empty;

    // A full FIFO still takes a write when a read frees a slot the same edge;
    // an empty FIFO never bypasses write data to the reader.
    assign wr_acc = wr_en && (!full || rd_en) && !flush;
    assign rd_acc = rd_en && !empty && !flush;
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    always_comb begin
        // NOTE: every next-state value is defaulted first so no path leaves a
        // signal unassigned and infers a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = wr_acc;
        overflow_d  = wr_en && full && !rd_en && !flush;
        underflow_d = rd_en && empty && !flush;

        if (wr_acc) wr_ptr_d = PW'(ptr_inc(int'(wr_ptr_q), FIFO_DEPTH));
        if (rd_acc) rd_ptr_d = PW'(ptr_inc(int'(rd_ptr_q), FIFO_DEPTH));

        unique case (op)
            OP_WR:   count_d = count_q + CW'(1);
            OP_RD:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    fifo_prog_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; rd_en only acknowledges it.
    assign data_out = empty ? '0 : rdata;
`else
    logic [FIFO_WIDTH-1:0] data_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else if (rd_acc) begin
            data_out_q <= rdata;
        end
    end

    assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// tb_fifo_prog: directed self-checking bench for fifo_prog (DEPTH=8 default
// instance plus a DEPTH=5 instance for non-power-of-two wrap).
module tb_fifo_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        flush, wr_en, rd_en;
    logic [15:0] din, dout;
    logic        wr_ack, ovf, udf, full, empty, af, ae;
    logic [3:0]  cnt;

    logic        flush5, wr_en5, rd_en5;
    logic [15:0] din5, dout5;
    logic        wr_ack5, ovf5, udf5, full5, empty5, af5, ae5;
    logic [2:0]  cnt5;

    fifo_prog u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_en       (wr_en),
        .data_in     (din),
        .rd_en       (rd_en),
        .data_out    (dout),
        .wr_ack      (wr_ack),
        .overflow    (ovf),
        .underflow   (udf),
        .full        (full),
        .empty       (empty),
        .almostfull  (af),
        .almostempty (ae),
        .count       (cnt)
    );

    fifo_prog #(
        .FIFO_WIDTH (16),
        .FIFO_DEPTH (5),
        .AF_THRESH  (3),
        .AE_THRESH  (2)
    ) u_dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush5),
        .wr_en       (wr_en5),
        .data_in     (din5),
        .rd_en       (rd_en5),
        .data_out    (dout5),
        .wr_ack      (wr_ack5),
        .overflow    (ovf5),
        .underflow   (udf5),
        .full        (full5),
        .empty       (empty5),
        .almostfull  (af5),
        .almostempty (ae5),
        .count       (cnt5)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {full, empty, almostfull, almostempty} expected for occupancy c.
    function automatic logic [3:0] flags_exp(input int c, input int depth, input int af_t, input int ae_t);
        return {c == depth, c == 0, (c >= af_t) && (c != depth), (c <= ae_t) && (c != 0)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state8(input string tag, input int c);
        check({tag, "_cnt"}, 32'(cnt), c);
        check({tag, "_flags"}, 32'({full, empty, af, ae}), 32'(flags_exp(c, 8, 7, 1)));
    endtask

    task automatic write8(input logic [15:0] d);
        wr_en = 1'b1;
        din   = d;
        tick;
    endtask

    // Leaves rd_en high so back-to-back calls read on consecutive edges.
    task automatic read8(input string tag, input logic [15:0] exp);
        rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
        check(tag, 32'(dout), 32'(exp));
`endif
        tick;
`ifndef FIFO_FWFT_EN
        check(tag, 32'(dout), 32'(exp));
`endif
    endtask

    logic [1:0]  ops [22];
    logic [15:0] q [$];
    logic [15:0] exp_w;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        flush5 = 1'b0; wr_en5 = 1'b0; rd_en5 = 1'b0; din5 = '0;

        // Reset values while reset is held.
        tick;
        check("rst_dout", 32'(dout), 0);
        check("rst_resp", 32'({wr_ack, ovf, udf}), 0);
        check_state8("rst", 0);
        check("rst5_flags", 32'({full5, empty5, af5, ae5}), 32'(4'b0100));
        #3 rst_n = 1'b1;
        tick;

        // Fill 8 words, then one write too many.
        for (int i = 1; i <= 8; i++) begin
            write8(16'(i));
            check("fill_ack", 32'(wr_ack), 1);
            check_state8("fill", i);
        end
        write8(16'h0009);
        check("ovf_flag", 32'(ovf), 1);
        check("ovf_ack", 32'(wr_ack), 0);
        check_state8("ovf", 8);
        wr_en = 1'b0;

        // Drain in order, then one read too many.
        for (int i = 1; i <= 8; i++) begin
            read8("drain_data", 16'(i));
            check_state8("drain", 8 - i);
        end
        tick;
        check("udf_flag", 32'(udf), 1);
`ifdef FIFO_FWFT_EN
        check("udf_dout", 32'(dout), 0);
`else
        check("udf_dout", 32'(dout), 32'h0008);
`endif
        rd_en = 1'b0;

        // Simultaneous read and write while full.
        for (int i = 0; i < 8; i++) write8(16'h0010 + 16'(i));
        wr_en = 1'b0;
        check_state8("refill", 8);
        wr_en = 1'b1; rd_en = 1'b1; din = 16'hBEEF;
`ifdef FIFO_FWFT_EN
        check("full_both_dout", 32'(dout), 32'h0010);
`endif
        tick;
        check("full_both_ack", 32'(wr_ack), 1);
        check_state8("full_both", 8);
`ifndef FIFO_FWFT_EN
        check("full_both_dout", 32'(dout), 32'h0010);
`endif
        wr_en = 1'b0;
        for (int i = 1; i < 8; i++) read8("after_both", 16'h0010 + 16'(i));
        read8("beef_last", 16'hBEEF);
        check_state8("both_drained", 0);

        // Simultaneous read and write while empty: no bypass.
        wr_en = 1'b1; rd_en = 1'b1; din = 16'h0055;
        tick;
        check("empty_both_resp", 32'({wr_ack, udf}), 32'(2'b11));
        check_state8("empty_both", 1);
        wr_en = 1'b0; rd_en = 1'b0;

        // Flush at count 5 overrides simultaneous write and read.
        for (int i = 0; i < 4; i++) write8(16'h0060 + 16'(i));
        wr_en = 1'b0;
        check_state8("pre_flush", 5);
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 16'h0077;
        tick;
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check_state8("flush", 0);
        check("flush_resp", 32'({wr_ack, ovf, udf}), 0);
`ifdef FIFO_FWFT_EN
        check("flush_dout", 32'(dout), 0);
`else
        check("flush_dout", 32'(dout), 32'hBEEF);
`endif
        write8(16'h00AA);
        wr_en = 1'b0;
        read8("post_flush", 16'h00AA);
        rd_en = 1'b0;
        check_state8("post_flush", 0);

        // DEPTH=5 instance: 12 writes and 12 reads, wrapping the pointers.
        ops = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                2'b01, 2'b01, 2'b01,
                2'b11, 2'b11,
                2'b10, 2'b10, 2'b10,
                2'b01, 2'b01, 2'b01, 2'b01,
                2'b10, 2'b10,
                2'b01, 2'b01, 2'b01};
        begin
            int wseq;
            bit wacc, racc;
            wseq = 0;
            for (int k = 0; k < 22; k++) begin
                wr_en5 = ops[k][1];
                rd_en5 = ops[k][0];
                din5   = 16'h0100 + 16'(wseq);
                wacc   = wr_en5 && ((q.size() < 5) || rd_en5);
                racc   = rd_en5 && (q.size() > 0);
`ifdef FIFO_FWFT_EN
                if (racc) check("d5_data", 32'(dout5), 32'(q[0]));
`endif
                tick;
                if (racc) begin
                    exp_w = q.pop_front();
`ifndef FIFO_FWFT_EN
                    check("d5_data", 32'(dout5), 32'(exp_w));
`endif
                end
                if (wacc) begin
                    q.push_back(din5);
                    wseq++;
                end
                check("d5_cnt", 32'(cnt5), q.size());
                check("d5_flags", 32'({full5, empty5, af5, ae5}), 32'(flags_exp(q.size(), 5, 3, 2)));
            end
            wr_en5 = 1'b0;
            rd_en5 = 1'b0;
            check("d5_total", wseq, 12);
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 4; i++) write8(16'h0030 + 16'(i));
        check_state8("pre_rst", 4);
        #3 rst_n = 1'b0;
        #1;
        check_state8("mid_rst", 0);
        check("mid_rst_resp", 32'({wr_ack, ovf, udf}), 0);
        check("mid_rst_dout", 32'(dout), 0);
        wr_en = 1'b0;
        #2 rst_n = 1'b1;
        tick;
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check("post_rst_udf", 32'(udf), 1);
        check_state8("post_rst", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
